// File: rtl/popcnt_pkg.sv
// popcnt_pkg: shared types and helpers for the sequential population counter.
//   state_t      : controller states (IDLE, COUNT, DONE)
//   mode_t       : count ones or count zeros
//   popcnt_cnt_w : result width needed to hold a count of 0..width
package popcnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic {
    CNT_ONES  = 1'b0,
    CNT_ZEROS = 1'b1
  } mode_t;

  function automatic int popcnt_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/popcnt_chunk.sv
// popcnt_chunk: combinational population count of one CHUNK-bit slice.
//   bits  : slice to count (already padded/masked by the caller)
//   count : number of ones in bits, $clog2(CHUNK+1) wide
module popcnt_chunk #(
  parameter  int CHUNK = 16,
  localparam int CW    = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/popcnt_seq.sv
// popcnt_seq: multi-cycle population counter, CHUNK bits per cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_data + in_mode sampled on accept
//   out_valid/out_ready : result handshake; out_count held while out_valid
//   busy                : high while counting
// Zero-counting inverts the operand at capture; chunk bits beyond WIDTH are
// forced to zero afterwards so padding never contributes in either mode.
module popcnt_seq
  import popcnt_pkg::*;
#(
  parameter  int WIDTH  = 128,
  parameter  int CHUNK  = 16,
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK,
  localparam int CNT_W  = popcnt_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW    = $clog2(CHUNK + 1);

  state_t                   state, state_nx;
  logic [WIDTH-1:0]         operand;
  logic [IDX_W-1:0]         idx;
  logic [CNT_W-1:0]         acc;
  logic                     armed;
  logic [NCHUNK*CHUNK-1:0]  padded;
  logic [CHUNK-1:0]         chunk;
  logic [CW-1:0]            chunk_cnt;
  logic                     accept;
  logic                     last;

  // armed keeps in_ready low during reset and until the first clock after it
  assign in_ready  = armed && (state == IDLE);
  assign busy      = (state == COUNT);
  assign out_valid = (state == DONE);
  assign out_count = acc;

  assign accept = in_valid && in_ready;
  assign last   = (idx == IDX_W'(NCHUNK - 1));

  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = operand;
  end

  assign chunk = padded[idx*CHUNK +: CHUNK];

  popcnt_chunk #(.CHUNK(CHUNK)) u_chunk (
    .bits  (chunk),
    .count (chunk_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = COUNT;
      COUNT:   if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed   <= 1'b0;
      operand <= '0;
      acc     <= '0;
      idx     <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        operand <= (mode_t'(in_mode) == CNT_ZEROS) ? ~in_data : in_data;
        acc     <= '0;
        idx     <= '0;
      end else if (state == COUNT) begin
        acc <= acc + CNT_W'(chunk_cnt);
        idx <= last ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_popcnt_seq.sv
// tb_popcnt_seq: three popcnt_seq instances (128/16, 9/4 padded, 128/128)
// driven with directed and random operands; results checked against a
// bit-loop reference count computed from the operand and mode.
module tb_popcnt_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid [3];
  logic         in_mode  [3];
  logic         out_ready[3];
  logic [127:0] in_data  [3];
  logic         in_ready [3];
  logic         out_valid[3];
  logic         busy     [3];
  logic [7:0]   cnt_a, cnt_c;
  logic [3:0]   cnt_b;
  logic [7:0]   cnt_o    [3];

  int width [3] = '{128, 9, 128};
  int nch   [3] = '{8, 3, 1};

  int n_vec = 0;
  int n_err = 0;

  assign cnt_o[0] = cnt_a;
  assign cnt_o[1] = {4'b0, cnt_b};
  assign cnt_o[2] = cnt_c;

  popcnt_seq #(.WIDTH(128), .CHUNK(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_mode(in_mode[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_count(cnt_a), .busy(busy[0]));

  popcnt_seq #(.WIDTH(9), .CHUNK(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1][8:0]), .in_mode(in_mode[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_count(cnt_b), .busy(busy[1]));

  popcnt_seq #(.WIDTH(128), .CHUNK(128)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .in_mode(in_mode[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_count(cnt_c), .busy(busy[2]));

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_count(input int w, input logic [127:0] d, input bit m);
    int ones = 0;
    for (int i = 0; i < w; i++) if (d[i]) ones++;
    return m ? (w - ones) : ones;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offer one operand on instance s, hold the result for `hold` cycles with
  // junk on the inputs, then consume it. Called on a falling edge.
  task automatic run_op(input int s, input logic [127:0] d, input bit m, input int hold);
    int exp, lat, waitc;
    exp   = ref_count(width[s], d, m);
    waitc = 0;
    while (!in_ready[s] && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk("ready_timeout", waitc < 50, 1);
    in_valid[s]  = 1'b1;
    in_data[s]   = d;
    in_mode[s]   = m;
    out_ready[s] = (hold == 0);
    @(negedge clk);
    in_valid[s] = 1'b0;
    in_data[s]  = rnd128();
    in_mode[s]  = ~m;
    chk("busy_in_count", busy[s], 1);
    chk("ready_in_count", in_ready[s], 0);
    lat = 0;
    while (!out_valid[s] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, nch[s]);
    chk("count", cnt_o[s], exp);
    for (int h = 0; h < hold; h++) begin
      in_valid[s] = 1'($urandom());
      in_data[s]  = rnd128();
      in_mode[s]  = 1'($urandom());
      @(negedge clk);
      chk("held_valid", out_valid[s], 1);
      chk("held_count", cnt_o[s], exp);
      chk("held_ready", in_ready[s], 0);
    end
    out_ready[s] = 1'b1;
    @(negedge clk);
    in_valid[s]  = 1'b0;
    out_ready[s] = 1'b0;
    chk("consumed_valid", out_valid[s], 0);
    chk("ready_after", in_ready[s], 1);
  endtask

  initial begin
    int bad;
    for (int s = 0; s < 3; s++) begin
      in_valid[s] = 1'b0; in_mode[s] = 1'b0; out_ready[s] = 1'b0; in_data[s] = '0;
    end
    #2;
    for (int s = 0; s < 3; s++) begin
      chk("rst_in_ready", in_ready[s], 0);
      chk("rst_out_valid", out_valid[s], 0);
      chk("rst_count", cnt_o[s], 0);
      chk("rst_busy", busy[s], 0);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", in_ready[0], 1);

    run_op(0, 128'h1FF, 1'b0, 0);
    run_op(0, {128{1'b1}}, 1'b0, 0);
    run_op(0, 128'h0, 1'b1, 0);
    run_op(1, 128'h000, 1'b1, 0);
    run_op(1, 128'h1FF, 1'b0, 0);
    run_op(0, 128'h0123_4567_89AB_CDEF_0F0F, 1'b0, 5);
    run_op(2, {16{8'hAA}}, 1'b0, 0);
    run_op(2, {16{8'hAA}}, 1'b1, 2);

    // reset in the third COUNT cycle of the 128/16 instance
    in_valid[0] = 1'b1; in_data[0] = {128{1'b1}}; in_mode[0] = 1'b0; out_ready[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid[0], 0);
    chk("abort_count", cnt_o[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_ready", in_ready[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid[0] || busy[0]) bad++;
    end
    chk("abort_no_result", bad, 0);
    out_ready[0] = 1'b0;
    run_op(0, 128'hF0, 1'b0, 0);

    for (int t = 0; t < 24; t++) begin
      int s;
      s = $urandom_range(0, 2);
      run_op(s, rnd128(), 1'($urandom()), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
